rr_request_arbiter: RTL and testbench
=====================================

// Module: rr_request_arbiter
// PURPOSE
//  Round-robin arbiter for 8 requesters sharing one downstream resource.
//  Registers a one-hot grant and its 3-bit binary index; the index drives the resource's select/mux.
//  Sequences each grant through request, hold and release phases.
//  Keeps a rotating priority pointer so that no requester starves.
// PARAMETERS
//  N_REQ     8    number of requesters (power of two)
//  ID_W      3    grant index width, log2(N_REQ)
//  MAX_HOLD  16   max GRANT cycles before forced revoke (only with ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  enable       in   1      arbitration enable
//  req          in   N_REQ  per-requester request level
//  done         in   1      holder finished; single-cycle pulse
//  grant        out  N_REQ  one-hot grant, registered
//  grant_valid  out  1      a grant is active
//  grant_id     out  ID_W   binary index of the granted requester, registered
//  timeout      out  1      one-cycle pulse when a grant is force-revoked
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - grant=0, grant_valid=0, grant_id=0, timeout=0.
//  - state=IDLE, pointer ptr=0, hold counter=0.
//  - Applies immediately, mid-grant included.
//  Interface rules
//  - Outputs are all registered.
//  - grant_valid == |grant.
//  - grant_id == index of the set bit in grant; it is 0 when grant_valid=0.
//  FSM: IDLE -> GRANT -> RELEASE -> IDLE
//  - IDLE: if enable && |req, choose the first set req searching ptr, ptr+1, ... mod N_REQ.
//    The choice is made in cycle t; grant/grant_id/grant_valid assert at t+1 (latency 1); go GRANT.
//  - GRANT: grant held stable.
//    Exit to RELEASE on the first cycle in which any of these holds:
//    done=1; req[grant_id]=0 (implicit release); enable=0.
//    Outputs clear on the following edge.
//    ptr <= grant_id+1 (wraps 7->0).
//  - RELEASE: one mandatory idle cycle with no grant (resource turnaround); always go IDLE.
//  - Back-to-back grants are therefore spaced by >=1 empty cycle.
//  Boundaries and special cases
//  - done in IDLE or RELEASE is ignored.
//  - done and a new req on the same cycle: release is taken first; the new req is considered in IDLE.
//  - req bits changing in IDLE are sampled only on the arbitration edge.
//  - Only the holder's req bit matters in GRANT.
//  - enable=0 in IDLE: no grant issued; ptr retained.
//  - All req=0 in IDLE: stay IDLE; outputs 0.
//  - A single requester may win consecutively if no other req is pending.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined
//  - Hold counter increments each GRANT cycle and clears on GRANT entry.
//  - If the counter reaches MAX_HOLD-1 with no release condition, go RELEASE.
//  - timeout=1 for exactly that one cycle (aligned with the grant clearing).
//  - ptr advances past the holder as for a normal release.
//  - A release condition on the same cycle takes priority: timeout stays 0.
//  ARB_TIMEOUT_EN undefined
//  - No counter logic; timeout tied 0.
//  - A grant is held indefinitely until a release condition occurs.
// STRUCTURE
//  Package arb_pkg
//  - state enum {IDLE, GRANT, RELEASE}.
//  - N_REQ/ID_W defaults.
//  - Function onehot2bin.
//  Sub-module rr_pick (combinational)
//  - Inputs req, ptr; outputs found, pick_id.
//  - Implemented as a rotate, priority-encode, un-rotate.
//  Top holds the FSM, ptr, output registers and the optional hold counter.
// TESTING
//  1 Reset, then req=8'h04, enable=1 -> next cycle grant=8'h04, grant_id=2, grant_valid=1.
//  2 Round robin:
//    - req=8'hFF held, done pulsed each grant.
//    - Expect grant_id sequence 0,1,2,...,7,0, with one empty cycle between grants.
//  3 Holder drop:
//    - Holder 5 with req=8'h21.
//    - Drop req[5] -> grant clears, 1 empty cycle, then grant_id=0.
//  4 Reset mid-grant:
//    - Drop rst_n while grant=8'h80 -> outputs 0 immediately, with no clock edge.
//    - After release, req=8'h81 -> grant_id=0 (ptr reset).
//  5 enable=0 during GRANT -> grant clears next edge; enable=0 in IDLE with req=8'hFF -> no grant.
//  6 ARB_TIMEOUT_EN, MAX_HOLD=16:
//    - Hold req[3] without done -> after 16 grant cycles timeout=1 for one cycle and grant clears.
//    - Next winner is 4 if req[4]=1.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and helpers for the round-robin request arbiter
package arb_pkg;

    localparam int N_REQ        = 8;
    localparam int ID_W         = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [ID_W-1:0] onehot2bin(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                bin = bin | ID_W'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_request_arbiter_if.sv
// rtl/rr_request_arbiter_if.sv - requester/arbiter handshake bundle
interface rr_request_arbiter_if;
    import arb_pkg::*;

    logic                 enable;
    logic [N_REQ-1:0]     req;
    logic                 done;
    logic [N_REQ-1:0]     grant;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout;

    modport master (
        output enable, req, done,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  enable, req, done,
        output grant, grant_valid, grant_id, timeout
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate by ptr, take lowest set bit, un-rotate
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  pick_id
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] lowest;

    // Rotating right by ptr puts requester ptr at bit 0, so lowest-set-bit is the round-robin winner.
    assign rot     = N_REQ'({req, req} >> ptr);
    assign lowest  = rot & (~rot + N_REQ'(1));
    assign pick_id = onehot2bin(lowest) + ptr;
    assign found   = |req;

endmodule

// File: rtl/rr_request_arbiter.sv
// rtl/rr_request_arbiter.sv - 8-way round-robin arbiter with request/hold/release sequencing
// Optional forced revoke of long grants when ARB_TIMEOUT_EN is defined.
module rr_request_arbiter
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
    input  logic                clk,
    input  logic                rst_n,
    rr_request_arbiter_if.slave arb
);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [N_REQ-1:0] grant_q, grant_nxt;
    logic [ID_W-1:0]  grant_id_q, grant_id_nxt;
    logic             grant_valid_q, grant_valid_nxt;
    logic             found;
    logic [ID_W-1:0]  pick_id;
    logic             release_cond;

    rr_pick u_pick (
        .req     (arb.req),
        .ptr     (ptr),
        .found   (found),
        .pick_id (pick_id)
    );

    assign release_cond = arb.done || !arb.req[grant_id_q] || !arb.enable;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              timeout_q, timeout_nxt;
`endif

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        grant_nxt       = grant_q;
        grant_id_nxt    = grant_id_q;
        grant_valid_nxt = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt    = hold_cnt;
        timeout_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (arb.enable && found) begin
                    state_nxt       = GRANT;
                    grant_nxt       = N_REQ'(1) << pick_id;
                    grant_id_nxt    = pick_id;
                    grant_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt    = '0;
`endif
                end
            end
            GRANT: begin
                if (release_cond) begin
                    state_nxt       = RELEASE;
                    grant_nxt       = '0;
                    grant_id_nxt    = '0;
                    grant_valid_nxt = 1'b0;
                    ptr_nxt         = grant_id_q + ID_W'(1);
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    // Revoke is treated exactly like a release, plus the one-cycle flag.
                    state_nxt       = RELEASE;
                    grant_nxt       = '0;
                    grant_id_nxt    = '0;
                    grant_valid_nxt = 1'b0;
                    ptr_nxt         = grant_id_q + ID_W'(1);
                    timeout_nxt     = 1'b1;
                end else begin
                    hold_cnt_nxt    = hold_cnt + HOLD_W'(1);
`endif
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt       = IDLE;
                grant_nxt       = '0;
                grant_id_nxt    = '0;
                grant_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            grant_q       <= grant_nxt;
            grant_id_q    <= grant_id_nxt;
            grant_valid_q <= grant_valid_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign arb.timeout = timeout_q;
`else
    assign arb.timeout = 1'b0;
`endif

    assign arb.grant       = grant_q;
    assign arb.grant_id    = grant_id_q;
    assign arb.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// tb/tb_rr_request_arbiter.sv - directed self-checking bench for rr_request_arbiter (ARB_TIMEOUT_EN aware)
`timescale 1ns/1ps
module tb_rr_request_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rr_request_arbiter_if arb ();

    rr_request_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        while (!arb.grant_valid && n < budget) begin
            tick();
            n++;
        end
        if (!arb.grant_valid) check("wait_grant", 32'(arb.grant_valid), 32'd1);
    endtask

    task automatic release_done();
        arb.done = 1'b1;
        tick();
        arb.done = 1'b0;
        check("done_clears", 32'(arb.grant_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        arb.enable = 1'b0;
        arb.req    = '0;
        arb.done   = 1'b0;
        tick();
        tick();
        check("rst_grant",   32'(arb.grant),       32'h0);
        check("rst_valid",   32'(arb.grant_valid), 32'h0);
        check("rst_id",      32'(arb.grant_id),    32'h0);
        check("rst_timeout", 32'(arb.timeout),     32'h0);
        rst_n = 1'b1;

        // single requester, latency one
        arb.req    = 8'h04;
        arb.enable = 1'b1;
        tick();
        check("t1_grant", 32'(arb.grant),       32'h04);
        check("t1_id",    32'(arb.grant_id),    32'd2);
        check("t1_valid", 32'(arb.grant_valid), 32'd1);
        release_done();
        arb.req = 8'h00;
        tick();
        tick();
        check("t1_idle_empty", 32'(arb.grant_valid), 32'd0);

        // full rotation from ptr=0
        pulse_reset();
        arb.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_grant(4);
            check("rr_id",    32'(arb.grant_id), 32'(i % 8));
            check("rr_grant", 32'(arb.grant),    32'(8'h01 << (i % 8)));
            release_done();
            check("rr_gap_id", 32'(arb.grant_id), 32'd0);
        end

        // holder drops its request; ptr is now 1
        arb.req = 8'h21;
        wait_grant(4);
        check("t3_id5", 32'(arb.grant_id), 32'd5);
        tick();
        check("t3_hold", 32'(arb.grant), 32'h20);
        arb.req = 8'h01;
        tick();
        check("t3_drop", 32'(arb.grant_valid), 32'd0);
        tick();
        check("t3_gap", 32'(arb.grant_valid), 32'd0);
        wait_grant(4);
        check("t3_id0", 32'(arb.grant_id), 32'd0);
        release_done();

        // asynchronous reset while requester 7 holds
        arb.req = 8'h80;
        wait_grant(4);
        check("t4_grant80", 32'(arb.grant), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_grant", 32'(arb.grant),       32'h0);
        check("t4_async_valid", 32'(arb.grant_valid), 32'h0);
        check("t4_async_id",    32'(arb.grant_id),    32'h0);
        tick();
        rst_n   = 1'b1;
        arb.req = 8'h81;
        wait_grant(4);
        check("t4_ptr_reset", 32'(arb.grant_id), 32'd0);
        release_done();

        // enable low during GRANT, then in IDLE; ptr is 1
        arb.req = 8'hFF;
        wait_grant(4);
        check("t5_id1", 32'(arb.grant_id), 32'd1);
        arb.enable = 1'b0;
        tick();
        check("t5_en_drop", 32'(arb.grant_valid), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_en_idle", 32'(arb.grant), 32'h0);
        arb.enable = 1'b1;
        wait_grant(4);
        check("t5_ptr_kept", 32'(arb.grant_id), 32'd2);
        release_done();

        // long hold by requester 3 with 4 waiting
        arb.req = 8'h18;
        wait_grant(4);
        check("t6_id3", 32'(arb.grant_id), 32'd3);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("t6_last_hold", 32'(arb.grant),   32'h08);
        check("t6_no_to_yet", 32'(arb.timeout), 32'd0);
        tick();
        check("t6_revoked",   32'(arb.grant_valid), 32'd0);
        check("t6_timeout",   32'(arb.timeout),     32'd1);
        tick();
        check("t6_to_pulse",  32'(arb.timeout),     32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("t6_held",    32'(arb.grant),   32'h08);
        check("t6_no_to",   32'(arb.timeout), 32'd0);
        release_done();
`endif
        wait_grant(4);
        check("t6_next4", 32'(arb.grant_id), 32'd4);
        release_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
